// File: rtl/disk_link_pkg.sv
// Shared definitions for both ends of the UART disk link: FSM states,
// protocol byte values and request-word bit positions.
package disk_link_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_ACK_WAIT,
    ST_RD_FETCH,
    ST_RD_LOAD,
    ST_RD_SEND,
    ST_WR_RECV,
    ST_BYE
  } disk_state_t;

  localparam logic [7:0] DISK_ACK_OK  = 8'hFF;
  localparam logic [7:0] DISK_ACK_BAD = 8'h00;
  localparam logic [7:0] DISK_BYE     = 8'hFF;

  localparam int DISK_SECTOR_BYTES = 512;

  localparam int DEV_SEL  = 31;
  localparam int DIR_WR   = 30;
  localparam int UART_SEL = 29;

  function automatic logic [7:0] ack_byte(input logic ok);
    return ok ? DISK_ACK_OK : DISK_ACK_BAD;
  endfunction

endpackage

// File: rtl/disk_req_decoder.sv
// Combinational decode of a 32-bit disk request word into valid / direction / sector.
import disk_link_pkg::*;

module disk_req_decoder #(
  parameter int SECTOR_AW = 6
) (
  input  logic [31:0]          word,
  output logic                 valid,
  output logic                 is_write,
  output logic [SECTOR_AW-1:0] sector
);

  // Sector numbers beyond the backing store are rejected, not truncated.
  assign valid    = word[DEV_SEL] & word[UART_SEL] & ~(|word[28:SECTOR_AW]);
  assign is_write = word[DIR_WR];
  assign sector   = word[SECTOR_AW-1:0];

endmodule

// File: rtl/disk_responder.sv
// Far end of the UART disk link: acks a 4-byte request, then streams or stores one sector.
// Optional inter-byte watchdog enabled by defining DISK_RESP_TIMEOUT_EN.
import disk_link_pkg::*;

module disk_responder #(
  parameter int SECTOR_AW      = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [SECTOR_AW+8:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 xfer_err,
  output logic                 last_is_write,
  output logic [SECTOR_AW-1:0] last_sector
);

  disk_state_t          state_reg, state_next;
  logic [9:0]           cnt_reg, cnt_next;
  logic [31:0]          req_reg, req_next;
  logic                 tx_start_reg, tx_start_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic [SECTOR_AW+8:0] mem_addr_reg, mem_addr_next;
  logic                 mem_we_reg, mem_we_next;
  logic [7:0]           mem_wdata_reg, mem_wdata_next;
  logic                 xfer_done_reg, xfer_done_next;
  logic                 xfer_err_reg, xfer_err_next;
  logic                 last_is_write_reg, last_is_write_next;
  logic [SECTOR_AW-1:0] last_sector_reg, last_sector_next;

  logic                 req_ok;
  logic                 req_wr;
  logic [SECTOR_AW-1:0] req_sector;
  logic [9:0]           cnt_inc;
  logic                 at_last;
  logic                 timeout;

  disk_req_decoder #(.SECTOR_AW(SECTOR_AW)) u_dec (
    .word     (req_reg),
    .valid    (req_ok),
    .is_write (req_wr),
    .sector   (req_sector)
  );

  assign cnt_inc = cnt_reg + 10'd1;
  assign at_last = (cnt_reg[8:0] == 9'd511);

`ifdef DISK_RESP_TIMEOUT_EN
  logic [31:0] wd_reg;

  assign timeout = (state_reg != ST_IDLE) && (wd_reg >= 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state_reg == ST_IDLE || rx_valid || tx_done || timeout)
      wd_reg <= '0;
    else
      wd_reg <= wd_reg + 32'd1;
  end
`else
  // Watchdog compiled out; the parameter stays for a uniform instance interface.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next         = state_reg;
    cnt_next           = cnt_reg;
    req_next           = req_reg;
    tx_start_next      = 1'b0;
    tx_data_next       = tx_data_reg;
    mem_addr_next      = mem_addr_reg;
    mem_we_next        = 1'b0;
    mem_wdata_next     = mem_wdata_reg;
    xfer_done_next     = 1'b0;
    xfer_err_next      = 1'b0;
    last_is_write_next = last_is_write_reg;
    last_sector_next   = last_sector_reg;

    case (state_reg)
      ST_IDLE, ST_REQ: begin
        if (rx_valid) begin
          req_next[{cnt_reg[1:0], 3'b000} +: 8] = rx_data;
          cnt_next   = cnt_inc;
          state_next = (cnt_reg[1:0] == 2'd3) ? ST_ACK : ST_REQ;
        end
      end
      ST_ACK: begin
        tx_start_next = 1'b1;
        tx_data_next  = ack_byte(req_ok);
        state_next    = ST_ACK_WAIT;
      end
      ST_ACK_WAIT: begin
        if (tx_done) begin
          cnt_next = '0;
          if (!req_ok) begin
            state_next = ST_IDLE;
          end else begin
            last_is_write_next = req_wr;
            last_sector_next   = req_sector;
            if (req_wr) begin
              state_next = ST_WR_RECV;
            end else begin
              mem_addr_next = {req_sector, 9'd0};
              state_next    = ST_RD_FETCH;
            end
          end
        end
      end
      // mem_addr is already presented here; read data lands during RD_LOAD.
      ST_RD_FETCH: state_next = ST_RD_LOAD;
      ST_RD_LOAD: begin
        tx_data_next  = mem_rdata;
        tx_start_next = 1'b1;
        state_next    = ST_RD_SEND;
      end
      ST_RD_SEND: begin
        if (tx_done) begin
          cnt_next = cnt_inc;
          if (at_last) begin
            state_next = ST_BYE;
          end else begin
            mem_addr_next = {last_sector_reg, cnt_inc[8:0]};
            state_next    = ST_RD_FETCH;
          end
        end
      end
      ST_WR_RECV: begin
        if (rx_valid) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = {last_sector_reg, cnt_reg[8:0]};
          mem_wdata_next = rx_data;
          cnt_next       = cnt_inc;
          if (at_last)
            state_next = ST_BYE;
        end
      end
      ST_BYE: begin
        if (rx_valid) begin
          xfer_done_next = (rx_data == DISK_BYE);
          xfer_err_next  = (rx_data != DISK_BYE);
          cnt_next       = '0;
          state_next     = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (timeout) begin
      state_next     = ST_IDLE;
      cnt_next       = '0;
      tx_start_next  = 1'b0;
      mem_we_next    = 1'b0;
      xfer_done_next = 1'b0;
      xfer_err_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      cnt_reg           <= '0;
      req_reg           <= '0;
      tx_start_reg      <= 1'b0;
      tx_data_reg       <= '0;
      mem_addr_reg      <= '0;
      mem_we_reg        <= 1'b0;
      mem_wdata_reg     <= '0;
      xfer_done_reg     <= 1'b0;
      xfer_err_reg      <= 1'b0;
      last_is_write_reg <= 1'b0;
      last_sector_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      cnt_reg           <= cnt_next;
      req_reg           <= req_next;
      tx_start_reg      <= tx_start_next;
      tx_data_reg       <= tx_data_next;
      mem_addr_reg      <= mem_addr_next;
      mem_we_reg        <= mem_we_next;
      mem_wdata_reg     <= mem_wdata_next;
      xfer_done_reg     <= xfer_done_next;
      xfer_err_reg      <= xfer_err_next;
      last_is_write_reg <= last_is_write_next;
      last_sector_reg   <= last_sector_next;
    end
  end

  assign tx_start      = tx_start_reg;
  assign tx_data       = tx_data_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_we        = mem_we_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign busy          = (state_reg != ST_IDLE);
  assign xfer_done     = xfer_done_reg;
  assign xfer_err      = xfer_err_reg;
  assign last_is_write = last_is_write_reg;
  assign last_sector   = last_sector_reg;

endmodule
